pipe_issue_ctrl: RTL
====================

PIPE_ISSUE_CTRL -- requirements
Module: pipe_issue_ctrl

Interface
REQ-001 The block SHALL provide port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL provide port `rst_n`, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of `clk`.
REQ-003 The block SHALL provide port `id_valid`, input, 1 bit: the decode stage presents an instruction.
REQ-004 The block SHALL provide port `id_inst`, input, 16 bits: instruction fields opcode[15:12], rd[11:9], rs1[8:6], rs2[5:3].
REQ-005 The block SHALL provide port `id_ready`, output, 1 bit: combinational; high when `id_inst` issues this cycle.
REQ-006 The block SHALL provide port `ex_valid`, output, 1 bit: registered; high for one cycle per issued instruction.
REQ-007 The block SHALL provide port `ex_inst`, output, 16 bits: registered copy of the issued instruction, feeding the execute stage.
REQ-008 The block SHALL provide port `wb_valid`, input, 1 bit: the writeback stage is committing a register write this cycle.
REQ-009 The block SHALL provide port `wb_rd`, input, 3 bits: destination register of that writeback.
REQ-010 The block SHALL provide port `flush`, input, 1 bit: discard the decode instruction and drain the pipeline.
REQ-011 The block SHALL provide port `busy_mask`, output, 8 bits: scoreboard, where bit n is high while register n has a pending write.
REQ-012 The block SHALL provide port `stall_cnt`, output, 8 bits: count of stalled cycles, saturating.
REQ-013 The block SHALL provide port `state`, output, 2 bits: current FSM state, with encoding RUN=00, STALL=01, DRAIN=10.

Function
REQ-014 Writer opcodes SHALL be ADD=0000, SUB=0001 and LOAD=0010; all other opcodes SHALL be non-writers that issue normally and never touch the scoreboard.
REQ-015 Source usage SHALL be: ADD and SUB read rs1 and rs2; LOAD reads rs1 only; non-writers read nothing.
REQ-016 The effective busy mask for hazard checks SHALL equal `busy_mask` with bit `wb_rd` cleared when `wb_valid` is high, so a writeback bypasses within the same cycle.
REQ-017 A hazard SHALL exist when any used source register, or the rd of a writer (WAW), is set in the effective busy mask.
REQ-018 `id_ready` SHALL equal id_valid AND state!=DRAIN AND no hazard AND NOT flush.
REQ-019 On a cycle with `id_ready` high, the next edge SHALL set ex_valid=1 and ex_inst=id_inst; otherwise ex_valid=0 and ex_inst holds its value. Issue latency SHALL be 1 cycle.
REQ-020 The scoreboard next value SHALL be (busy_mask AND NOT wb_clear) OR issue_set; when set and clear target the same register, the set SHALL win.
REQ-021 A `wb_valid` pulse for a register that is not busy SHALL be ignored, with no error.
REQ-022 FSM from RUN: on flush, go to DRAIN; else on id_valid with hazard, go to STALL; else stay in RUN.
REQ-023 FSM from STALL: on flush, go to DRAIN; else when the hazard clears (issue occurs) or id_valid drops, go to RUN; else stay in STALL.
REQ-024 FSM from DRAIN: no issue; go to RUN on the cycle after the effective busy mask reaches zero; a flush while in DRAIN SHALL keep DRAIN.
REQ-025 `stall_cnt` SHALL increment by 1 on each cycle with id_valid=1, id_ready=0 and state!=DRAIN, and SHALL saturate at 255.
REQ-026 A flush SHALL neither clear the scoreboard nor cancel an `ex_valid` already registered; in-flight writers still retire through `wb_valid`.

Reset
REQ-027 While rst_n=0 at a clock edge, the outputs SHALL take ex_valid=0, ex_inst=16'h0000, busy_mask=8'h00, stall_cnt=8'h00, state=RUN.
REQ-028 While rst_n=0, `id_ready` SHALL be 0.
REQ-029 Reset mid-operation SHALL abandon pending scoreboard entries, and later `wb_valid` pulses for those entries SHALL be ignored.
REQ-030 The first issue after reset SHALL be possible in the cycle after rst_n returns to 1.

Verification
REQ-031 Back-to-back independent instructions: ADD r1,r2,r3 then SUB r4,r5,r6 on consecutive cycles -> ex_valid high two cycles, busy_mask=8'h12, stall_cnt=0.
REQ-032 RAW stall: ADD r1 issued, then ADD r2,r1,r3 presented, wb_valid/wb_rd=1 arrives 3 cycles later -> id_ready low 3 cycles and high on the wb cycle (bypass), stall_cnt=3, state STALL then RUN.
REQ-033 Same-register set/clear: LOAD r5 issues while wb_valid with wb_rd=5 (old r5 write) -> busy_mask[5]=1 afterwards.
REQ-034 Flush: busy_mask=8'h06, flush pulse -> state=DRAIN with no issue despite id_valid; after wb of r1 and r2, state=RUN one cycle later.
REQ-035 Saturation: hold a hazard for 300 cycles -> stall_cnt=255.
REQ-036 Reset mid-stall: rst_n=0 for one cycle during STALL -> all outputs at reset values, and a stale wb_rd pulse afterwards leaves busy_mask=0.

Source files
------------

// File: rtl/pipe_issue_ctrl.sv
// Single-issue control for a short in-order pipeline: a register scoreboard
// drives RAW/WAW stalls, flush drains the pipe, and the stall cycles are counted.
module pipe_issue_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [15:0] id_inst,
    output logic        id_ready,
    output logic        ex_valid,
    output logic [15:0] ex_inst,
    input  logic        wb_valid,
    input  logic [2:0]  wb_rd,
    input  logic        flush,
    output logic [7:0]  busy_mask,
    output logic [7:0]  stall_cnt,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t      state_q;
    logic        vld_p1;
    logic [15:0] inst_p1;
    logic [7:0]  busy_q;
    logic [7:0]  stall_q;

    logic [3:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        writer;
    logic        hazard;
    logic        stall_cycle;
    logic [7:0]  wb_clear;
    logic [7:0]  eff_busy;
    logic [7:0]  issue_set;

    function automatic logic is_writer(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010);
    endfunction

    function automatic logic reads_rs1(input logic [3:0] op);
        return is_writer(op);
    endfunction

    function automatic logic reads_rs2(input logic [3:0] op);
        return (op == 4'b0000) || (op == 4'b0001);
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

    function automatic logic [7:0] onehot(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // Decode stage: field extraction and hazard detection against the scoreboard
    assign opcode = id_inst[15:12];
    assign rd     = id_inst[11:9];
    assign rs1    = id_inst[8:6];
    assign rs2    = id_inst[5:3];
    assign writer = is_writer(opcode);

    // A writeback this cycle is visible to the hazard check immediately.
    assign wb_clear = wb_valid ? onehot(wb_rd) : 8'h00;
    assign eff_busy = busy_q & ~wb_clear;

    assign hazard = (reads_rs1(opcode) && eff_busy[rs1])
                  | (reads_rs2(opcode) && eff_busy[rs2])
                  | (writer && eff_busy[rd]);

    assign id_ready = rst_n & id_valid & (state_q != DRAIN) & ~hazard & ~flush;

    assign issue_set   = (id_ready && writer) ? onehot(rd) : 8'h00;
    assign stall_cycle = id_valid & ~id_ready & (state_q != DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush)
                        state_q <= DRAIN;
                    else if (id_valid && hazard)
                        state_q <= STALL;
                end
                STALL: begin
                    if (flush)
                        state_q <= DRAIN;
                    else if (id_ready || !id_valid)
                        state_q <= RUN;
                end
                DRAIN: begin
                    // Leave only once every in-flight writer has retired.
                    if (!flush && (eff_busy == 8'h00))
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Scoreboard and stall counter: a set on the same register beats its clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q  <= 8'h00;
            stall_q <= 8'h00;
        end else begin
            busy_q <= eff_busy | issue_set;
            if (stall_cycle)
                stall_q <= sat_inc(stall_q);
        end
    end

    // Execute stage boundary: registered issue
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            inst_p1 <= 16'h0000;
        end else begin
            vld_p1 <= id_ready;
            if (id_ready)
                inst_p1 <= id_inst;
        end
    end

    assign ex_valid  = vld_p1;
    assign ex_inst   = inst_p1;
    assign busy_mask = busy_q;
    assign stall_cnt = stall_q;
    assign state     = state_q;

endmodule
